// File: rtl/comparator_pkg.sv
// Shared types for serial_magnitude_comparator: FSM states and the internal compare result.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_GT = 2'd1,
    CMP_EQ = 2'd2
  } cmp_t;

endpackage

// File: rtl/chunk_compare.sv
// Combinational CHUNK-bit magnitude compare; msb_invert flips the top bit of both
// operands so a two's-complement chunk orders correctly under an unsigned compare.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_invert,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  logic [CHUNK-1:0] mask;
  logic [CHUNK-1:0] ax;
  logic [CHUNK-1:0] bx;

  always_comb begin
    mask            = '0;
    mask[CHUNK-1]   = msb_invert;
    ax              = a ^ mask;
    bx              = b ^ mask;
    lt              = (ax < bx);
    gt              = (ax > bx);
    eq              = (ax == bx);
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning CHUNK bits per cycle, MSB chunk first.
// Define SIGNED_CMP_EN to add the signed_mode port for two's-complement compares.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             e
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  cmp_t               res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic               diff_q, diff_d;
  cmp_t               diff_res_q, diff_res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sm_q, sm_d;

  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic               msb_inv;
  logic               c_lt, c_gt, c_eq;

  assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
  assign slice_b = b_q[idx_q*CHUNK +: CHUNK];
  // Only the top chunk carries the sign bit.
  assign msb_inv = sm_q && (idx_q == IDXW'(NCHUNK - 1));

  chunk_compare #(.CHUNK(CHUNK)) u_chunk (
    .a          (slice_a),
    .b          (slice_b),
    .msb_invert (msb_inv),
    .lt         (c_lt),
    .gt         (c_gt),
    .eq         (c_eq)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    diff_d      = diff_q;
    diff_res_d  = diff_res_q;
    sm_d        = sm_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
`ifdef SIGNED_CMP_EN
          sm_d    = signed_mode;
`else
          sm_d    = 1'b0;
`endif
          idx_d   = IDXW'(NCHUNK - 1);
          diff_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!c_eq && (EARLY_EXIT != 0)) begin
          res_d       = c_lt ? CMP_LT : CMP_GT;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          // Without early exit, the most significant difference wins.
          if (!c_eq && !diff_q) begin
            diff_d     = 1'b1;
            diff_res_d = c_gt ? CMP_GT : CMP_LT;
          end
          if (idx_q == '0) begin
            res_d       = diff_d ? diff_res_d : CMP_EQ;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      res_q       <= CMP_EQ;
      res_valid_q <= 1'b0;
      diff_q      <= 1'b0;
      diff_res_q  <= CMP_EQ;
      sm_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      diff_q      <= diff_d;
      diff_res_q  <= diff_res_d;
      sm_q        <= sm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign l    = res_valid_q && (res_q == CMP_LT);
  assign g    = res_valid_q && (res_q == CMP_GT);
  assign e    = res_valid_q && (res_q == CMP_EQ);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: one early-exit and one full-scan comparator share operands;
// a reference model predicts flags and done cycle, monitors pop and compare.
module tb_serial_magnitude_comparator;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;
`ifdef SIGNED_CMP_EN
  localparam bit HAS_SIGNED = 1'b1;
`else
  localparam bit HAS_SIGNED = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] lge;
    int         dcyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0, start1;
  logic [W-1:0]  a, b;
  logic          sm;
  logic          busy0, done0, l0, g0, e0;
  logic          busy1, done1, l1, g1, e1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [2:0] last0, last1;
  bit   lv0 = 0, lv1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_magnitude_comparator #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
`ifdef SIGNED_CMP_EN
    .signed_mode(sm),
`endif
    .busy(busy0), .done(done0), .l(l0), .g(g0), .e(e0)
  );

  serial_magnitude_comparator #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
`ifdef SIGNED_CMP_EN
    .signed_mode(sm),
`endif
    .busy(busy1), .done(done1), .l(l1), .g(g1), .e(e1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: {l,g,e} from plain integer ordering.
  function automatic logic [2:0] ref_lge(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    int xi, yi;
    if (s) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    if (xi < yi) return 3'b100;
    if (xi > yi) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from accept to done: first differing chunk (1 = MSB), or N.
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
    logic [W-1:0] d;
    d = x ^ y;
    if (!ee) return N;
    for (int n = 1; n <= N; n++)
      if ((d >> (W - n * C)) != 0) return n;
    return N;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0 unexpected done at cycle %0d", cyc);
        end else begin
          exp_t ex;
          ex = q0.pop_front();
          $display("dut0 txn flags lge=%b at cycle %0d", {l0, g0, e0}, cyc);
          chk("dut0 flags", int'({l0, g0, e0}), int'(ex.lge));
          chk("dut0 done cycle", cyc, ex.dcyc);
          last0 = {l0, g0, e0};
          lv0 = 1;
        end
      end else if (busy0 && lv0) begin
        chk("dut0 hold during run", int'({l0, g0, e0}), int'(last0));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1 unexpected done at cycle %0d", cyc);
        end else begin
          exp_t ex;
          ex = q1.pop_front();
          $display("dut1 txn flags lge=%b at cycle %0d", {l1, g1, e1}, cyc);
          chk("dut1 flags", int'({l1, g1, e1}), int'(ex.lge));
          chk("dut1 done cycle", cyc, ex.dcyc);
          last1 = {l1, g1, e1};
          lv1 = 1;
        end
      end else if (busy1 && lv1) begin
        chk("dut1 hold during run", int'({l1, g1, e1}), int'(last1));
      end
    end
  end

  // Called at a negedge with the selected DUTs able to accept; returns at the next negedge.
  task automatic issue(input bit d0, input bit d1, input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    bit se;
    exp_t ex;
    se = s && HAS_SIGNED;
    a = x; b = y; sm = s;
    start0 = d0; start1 = d1;
    if (d0) begin
      ex.lge = ref_lge(x, y, se); ex.dcyc = cyc + 1 + ref_lat(x, y, 1'b1);
      q0.push_back(ex);
    end
    if (d1) begin
      ex.lge = ref_lge(x, y, se); ex.dcyc = cyc + 1 + ref_lat(x, y, 1'b0);
      q1.push_back(ex);
    end
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    if (d0) chk("dut0 busy after accept", int'(busy0), 1);
    if (d1) chk("dut1 busy after accept", int'(busy1), 1);
  endtask

  task automatic wait_done(input int which);
    for (int i = 0; i < 100; i++) begin
      if ((which == 0) ? done0 : done1) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL dut%0d done timeout at cycle %0d", which, cyc);
    if (which == 0) q0.delete(); else q1.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dut0 busy/done/l/g/e"}, int'({busy0, done0, l0, g0, e0}), 0);
    chk({tag, " dut1 busy/done/l/g/e"}, int'({busy1, done1, l1, g1, e1}), 0);
  endtask

  initial begin
    logic [W-1:0] x, y;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; a = '0; b = '0; sm = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(1, 1, 16'h1234, 16'h1234, 0);
    wait_done(1);
    issue(1, 0, 16'h1235, 16'h1234, 0);
    wait_done(0);
    issue(1, 0, 16'h0FFF, 16'h1000, 0);   // back-to-back from DONE
    wait_done(0);
    @(negedge clk);
    issue(1, 1, 16'h8000, 16'h7FFF, 0);
    wait_done(1);
    issue(1, 1, 16'h8000, 16'h7FFF, 1);
    wait_done(1);
    issue(0, 1, 16'hF000, 16'h0000, 0);
    wait_done(1);
    issue(1, 1, 16'h1200, 16'h0300, 0);
    wait_done(1);

    // Re-pulsed start during a run must be ignored.
    issue(1, 0, 16'h1234, 16'h1234, 0);
    a = 16'h0000; b = 16'hFFFF; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    @(negedge clk);
    wait_done(0);
    @(negedge clk);

    // Reset mid-run: no done, outputs cleared.
    issue(1, 1, 16'hABCD, 16'hABCD, 0);
    @(negedge clk);
    rst = 1'b1;
    q0.delete(); q1.delete();
    lv0 = 0; lv1 = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid-run reset");
    repeat (6) @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      x = W'($urandom);
      case ($urandom_range(3, 0))
        0: y = x;
        1: y = x ^ W'(1 << $urandom_range(W - 1, 0));
        default: y = W'($urandom);
      endcase
      issue(1, 1, x, y, 1'($urandom_range(1, 0)));
      wait_done(1);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
